// File: rtl/sp_bram_ctrl.sv
// Request/response front-end for a single-port write-first BRAM with 1-cycle read latency.
// Partial-strobe writes become read-modify-write; read data returns through an in-order FIFO.
module sp_bram_ctrl #(
    parameter  int DATA_WIDTH = 32,
    parameter  int NUM_SETS   = 1024,
    parameter  int RSP_DEPTH  = 2,
    localparam int ADDR_W     = $clog2(NUM_SETS),
    localparam int STRB_W     = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_ni,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [STRB_W-1:0]     req_wstrb,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  bram_en,
    output logic [ADDR_W-1:0]     bram_addr,
    output logic                  bram_wr_en,
    output logic [DATA_WIDTH-1:0] bram_wr_data,
    input  logic [DATA_WIDTH-1:0] bram_rd_data,
    output logic                  busy
);

    localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CNT_W = $clog2(RSP_DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RSP_DEPTH - 1);
    localparam logic [CNT_W:0]   DEPTH_C  = (CNT_W + 1)'(RSP_DEPTH);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RMW  = 1'b1
    } state_t;

    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] new_d,
        input logic [DATA_WIDTH-1:0] old_d,
        input logic [STRB_W-1:0]     strb
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_d;
        for (int b = 0; b < STRB_W; b++) begin
            res[b*8 +: 8] = strb[b] ? new_d[b*8 +: 8] : old_d[b*8 +: 8];
        end
        return res;
    endfunction

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_LAST) ? PTR_W'(0) : ptr + PTR_W'(1);
    endfunction

    state_t                state_q, state_d;
    logic                  rd_pend_q, rd_pend_d;
    logic [CNT_W-1:0]      cnt_q;
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [DATA_WIDTH-1:0] fifo_q [RSP_DEPTH];
    logic [ADDR_W-1:0]     rmw_addr_q;
    logic [DATA_WIDTH-1:0] rmw_wdata_q;
    logic [STRB_W-1:0]     rmw_wstrb_q;

    logic                  latch_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  credit_ok_s;
    logic [CNT_W:0]        occ_s;

    assign rsp_valid = (cnt_q != CNT_W'(0));
    assign rsp_rdata = fifo_q[rd_ptr_q];
    assign pop_s     = rsp_valid && rsp_ready;
    assign push_s    = rd_pend_q;
    assign busy      = (state_q != ST_IDLE) || rd_pend_q || rsp_valid;

    // Read credit: entries held plus the in-flight read, minus this cycle's pop, must leave room.
    assign occ_s       = {1'b0, cnt_q} + {{CNT_W{1'b0}}, rd_pend_q} - {{CNT_W{1'b0}}, pop_s};
    assign credit_ok_s = (occ_s < DEPTH_C);

    // Request acceptance and BRAM command generation.
    always_comb begin
        state_d      = state_q;
        rd_pend_d    = 1'b0;
        latch_s      = 1'b0;
        req_ready    = 1'b0;
        bram_en      = 1'b0;
        bram_wr_en   = 1'b0;
        bram_addr    = req_addr;
        bram_wr_data = req_wdata;
        case (state_q)
            ST_IDLE: begin
                req_ready = rst_ni && (req_we || credit_ok_s);
                if (req_valid && req_ready) begin
                    if (!req_we) begin
                        bram_en   = 1'b1;
                        rd_pend_d = 1'b1;
                    end else if (req_wstrb == {STRB_W{1'b1}}) begin
                        bram_en    = 1'b1;
                        bram_wr_en = 1'b1;
                    end else if (req_wstrb != {STRB_W{1'b0}}) begin
                        bram_en = 1'b1;
                        latch_s = 1'b1;
                        state_d = ST_RMW;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RMW: begin
                bram_en      = rst_ni;
                bram_wr_en   = rst_ni;
                bram_addr    = rmw_addr_q;
                bram_wr_data = merge_bytes(rmw_wdata_q, bram_rd_data, rmw_wstrb_q);
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state, read-pending flag and FIFO occupancy/pointers.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            rd_pend_q <= 1'b0;
            cnt_q     <= CNT_W'(0);
            wr_ptr_q  <= PTR_W'(0);
            rd_ptr_q  <= PTR_W'(0);
        end else begin
            state_q   <= state_d;
            rd_pend_q <= rd_pend_d;
            if (push_s) begin
                wr_ptr_q <= next_ptr(wr_ptr_q);
            end else begin
                wr_ptr_q <= wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_q <= next_ptr(rd_ptr_q);
            end else begin
                rd_ptr_q <= rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // FIFO storage and the RMW operand latch.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < RSP_DEPTH; i++) begin
                fifo_q[i] <= {DATA_WIDTH{1'b0}};
            end
            rmw_addr_q  <= {ADDR_W{1'b0}};
            rmw_wdata_q <= {DATA_WIDTH{1'b0}};
            rmw_wstrb_q <= {STRB_W{1'b0}};
        end else begin
            if (push_s) begin
                fifo_q[wr_ptr_q] <= bram_rd_data;
            end else begin
                fifo_q[wr_ptr_q] <= fifo_q[wr_ptr_q];
            end
            if (latch_s) begin
                rmw_addr_q  <= req_addr;
                rmw_wdata_q <= req_wdata;
                rmw_wstrb_q <= req_wstrb;
            end else begin
                rmw_addr_q  <= rmw_addr_q;
                rmw_wdata_q <= rmw_wdata_q;
                rmw_wstrb_q <= rmw_wstrb_q;
            end
        end
    end

endmodule

// File: tb/tb_sp_bram_ctrl.sv
// Self-checking bench for sp_bram_ctrl with a behavioural write-first BRAM model.
module tb_sp_bram_ctrl;

    logic        clk;
    logic        rst_ni;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [9:0]  req_addr;
    logic [3:0]  req_wstrb;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        bram_en;
    logic [9:0]  bram_addr;
    logic        bram_wr_en;
    logic [31:0] bram_wr_data;
    logic [31:0] bram_rd_data;
    logic        busy;

    int total_cnt  = 0;
    int passed_cnt = 0;

    sp_bram_ctrl #(.DATA_WIDTH(32), .NUM_SETS(1024), .RSP_DEPTH(2)) dut (
        .clk(clk), .rst_ni(rst_ni),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wstrb(req_wstrb), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .bram_en(bram_en), .bram_addr(bram_addr), .bram_wr_en(bram_wr_en),
        .bram_wr_data(bram_wr_data), .bram_rd_data(bram_rd_data), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write-first single-port BRAM, registered read data.
    logic [31:0] mem [1024];
    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        bram_rd_data = 32'h0;
    end
    always @(posedge clk) begin
        if (bram_en) begin
            if (bram_wr_en) begin
                mem[bram_addr] <= bram_wr_data;
                bram_rd_data   <= bram_wr_data;
            end else begin
                bram_rd_data <= mem[bram_addr];
            end
        end
    end

    typedef struct packed {
        logic        v;
        logic        we;
        logic [9:0]  a;
        logic [3:0]  s;
        logic [31:0] wd;
        logic        rr;
        logic        e_rdy;
        logic        e_en;
        logic        e_wen;
        logic        e_rv;
        logic [1:0]  chk;   // 0 none, 1 rsp_rdata, 2 bram_wr_data
        logic [31:0] e_d;
    } vec_t;

    function automatic vec_t mk(input logic v, input logic we, input logic [9:0] a,
                                input logic [3:0] s, input logic [31:0] wd, input logic rr,
                                input logic e_rdy, input logic e_en, input logic e_wen,
                                input logic e_rv, input logic [1:0] chk, input logic [31:0] e_d);
        vec_t r;
        r.v = v; r.we = we; r.a = a; r.s = s; r.wd = wd; r.rr = rr;
        r.e_rdy = e_rdy; r.e_en = e_en; r.e_wen = e_wen; r.e_rv = e_rv;
        r.chk = chk; r.e_d = e_d;
        return r;
    endfunction

    function automatic logic [31:0] pat(input int i);
        return 32'hC0DE_0000 + 32'(i) * 32'h0000_0101;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
        else passed_cnt++;
    endtask

    task automatic drive(input logic v, input logic we, input logic [9:0] a,
                         input logic [3:0] s, input logic [31:0] wd, input logic rr);
        req_valid = v; req_we = we; req_addr = a; req_wstrb = s; req_wdata = wd; rsp_ready = rr;
        #1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[14];

    initial begin
        vecs[0]  = mk(1'b1, 1'b1, 10'd9, 4'hF, 32'h12345678, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 32'h0);
        vecs[1]  = mk(1'b1, 1'b1, 10'd5, 4'hF, 32'hAABBCCDD, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 32'h0);
        vecs[2]  = mk(1'b1, 1'b0, 10'd5, 4'h0, 32'h0,        1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 32'h0);
        vecs[3]  = mk(1'b0, 1'b0, 10'd0, 4'h0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
        vecs[4]  = mk(1'b0, 1'b0, 10'd0, 4'h0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 32'hAABBCCDD);
        vecs[5]  = mk(1'b1, 1'b1, 10'd5, 4'h3, 32'h11223344, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 32'h0);
        vecs[6]  = mk(1'b1, 1'b0, 10'd5, 4'h0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd2, 32'hAABB3344);
        vecs[7]  = mk(1'b1, 1'b0, 10'd5, 4'h0, 32'h0,        1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 32'h0);
        vecs[8]  = mk(1'b0, 1'b0, 10'd0, 4'h0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
        vecs[9]  = mk(1'b0, 1'b0, 10'd0, 4'h0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 32'hAABB3344);
        vecs[10] = mk(1'b1, 1'b1, 10'd9, 4'h0, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
        vecs[11] = mk(1'b1, 1'b0, 10'd9, 4'h0, 32'h0,        1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 32'h0);
        vecs[12] = mk(1'b0, 1'b0, 10'd0, 4'h0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
        vecs[13] = mk(1'b0, 1'b0, 10'd0, 4'h0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 32'h12345678);

        // Reset state, with a request presented to show it is not accepted.
        rst_ni = 1'b0;
        drive(1'b1, 1'b1, 10'd3, 4'hF, 32'hFFFF0000, 1'b1);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_bram_en",   32'(bram_en),   32'd0);
        chk("rst_bram_wr",   32'(bram_wr_en), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        drive(1'b0, 1'b0, 10'd0, 4'h0, 32'h0, 1'b1);
        next_cycle();
        rst_ni = 1'b1;
        #1;
        chk("post_rst_req_ready", 32'(req_ready), 32'd1);
        next_cycle();

        // Tests 1, 2, 5 as a cycle-by-cycle table.
        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].v, vecs[i].we, vecs[i].a, vecs[i].s, vecs[i].wd, vecs[i].rr);
            chk($sformatf("v%0d_req_ready", i), 32'(req_ready), 32'(vecs[i].e_rdy));
            chk($sformatf("v%0d_bram_en", i),   32'(bram_en),   32'(vecs[i].e_en));
            chk($sformatf("v%0d_bram_wr", i),   32'(bram_wr_en), 32'(vecs[i].e_wen));
            chk($sformatf("v%0d_rsp_valid", i), 32'(rsp_valid), 32'(vecs[i].e_rv));
            if (vecs[i].chk == 2'd1) chk($sformatf("v%0d_rsp_rdata", i), rsp_rdata, vecs[i].e_d);
            else if (vecs[i].chk == 2'd2) chk($sformatf("v%0d_bram_wr_data", i), bram_wr_data, vecs[i].e_d);
            next_cycle();
        end

        // Test 3: fill 0..7 then stream reads every cycle with rsp_ready high.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, 10'(i), 4'hF, pat(i), 1'b1);
            next_cycle();
        end
        for (int k = 0; k < 11; k++) begin
            if (k < 8) begin
                drive(1'b1, 1'b0, 10'(k), 4'h0, 32'h0, 1'b1);
                chk($sformatf("stream%0d_req_ready", k), 32'(req_ready), 32'd1);
            end else begin
                drive(1'b0, 1'b0, 10'd0, 4'h0, 32'h0, 1'b1);
            end
            chk($sformatf("stream%0d_rsp_valid", k), 32'(rsp_valid), 32'((k >= 2) && (k < 10)));
            if ((k >= 2) && (k < 10)) chk($sformatf("stream%0d_rdata", k), rsp_rdata, pat(k - 2));
            next_cycle();
        end

        // Test 4: backpressure with a 2-entry FIFO.
        drive(1'b1, 1'b0, 10'd0, 4'h0, 32'h0, 1'b0);
        chk("bp_c0_req_ready", 32'(req_ready), 32'd1);
        next_cycle();
        drive(1'b1, 1'b0, 10'd1, 4'h0, 32'h0, 1'b0);
        chk("bp_c1_req_ready", 32'(req_ready), 32'd1);
        next_cycle();
        drive(1'b1, 1'b0, 10'd2, 4'h0, 32'h0, 1'b0);
        chk("bp_c2_req_ready", 32'(req_ready), 32'd0);
        next_cycle();
        drive(1'b1, 1'b0, 10'd2, 4'h0, 32'h0, 1'b0);
        chk("bp_c3_req_ready", 32'(req_ready), 32'd0);
        chk("bp_c3_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("bp_c3_busy",      32'(busy),      32'd1);
        next_cycle();
        drive(1'b1, 1'b0, 10'd2, 4'h0, 32'h0, 1'b1);
        chk("bp_c4_req_ready", 32'(req_ready), 32'd1);
        chk("bp_c4_rdata",     rsp_rdata,      pat(0));
        next_cycle();
        drive(1'b0, 1'b0, 10'd0, 4'h0, 32'h0, 1'b1);
        chk("bp_c5_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("bp_c5_rdata",     rsp_rdata,      pat(1));
        next_cycle();
        chk("bp_c6_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("bp_c6_rdata",     rsp_rdata,      pat(2));
        next_cycle();
        chk("bp_c7_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("bp_c7_busy",      32'(busy),      32'd0);

        // Test 6: reset during the RMW write cycle leaves memory untouched.
        drive(1'b1, 1'b1, 10'd5, 4'hF, 32'hAABBCCDD, 1'b1);
        next_cycle();
        drive(1'b1, 1'b1, 10'd5, 4'h3, 32'h11223344, 1'b1);
        chk("rmwrst_req_ready", 32'(req_ready), 32'd1);
        next_cycle();
        drive(1'b0, 1'b0, 10'd0, 4'h0, 32'h0, 1'b1);
        chk("rmwrst_in_rmw_wr", 32'(bram_wr_en), 32'd1);
        rst_ni = 1'b0;
        #1;
        chk("rmwrst_req_ready0", 32'(req_ready), 32'd0);
        chk("rmwrst_bram_en",    32'(bram_en),   32'd0);
        chk("rmwrst_bram_wr",    32'(bram_wr_en), 32'd0);
        chk("rmwrst_rsp_valid",  32'(rsp_valid), 32'd0);
        chk("rmwrst_busy",       32'(busy),      32'd0);
        next_cycle();
        rst_ni = 1'b1;
        #1;
        chk("rmwrst_release_ready", 32'(req_ready), 32'd1);
        next_cycle();
        drive(1'b1, 1'b0, 10'd5, 4'h0, 32'h0, 1'b1);
        next_cycle();
        drive(1'b0, 1'b0, 10'd0, 4'h0, 32'h0, 1'b1);
        next_cycle();
        chk("rmwrst_rsp_valid_after", 32'(rsp_valid), 32'd1);
        chk("rmwrst_mem_unchanged",   rsp_rdata,      32'hAABBCCDD);
        next_cycle();

        $display("%0d/%0d checks passed", passed_cnt, total_cnt);
        $finish;
    end

endmodule
